// File: rtl/display_pager_pkg.sv
// Shared display types: page ids, date/time record, BCD and weekday glyph helpers.
// Glyphs are active-low GFEDCBA (bit 6 = G).
package display_pager_pkg;

    typedef enum logic [1:0] {PG_TIME, PG_SEC, PG_DAY, PG_DATE} page_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef struct packed {
        logic [7:0] year;
        logic [7:0] month;
        logic [2:0] day_of_week;
        logic [7:0] day;
        logic [7:0] hour;
        logic [7:0] minute;
        logic [7:0] second;
    } if_date_time;

    // Nibbles A-F fall through to their hex glyphs rather than blanking.
    function automatic logic [6:0] bcd_digit(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            4'hF: return 7'h0E;
        endcase
    endfunction

    // {left, right} char pair; 1 = Monday .. 7 = Sunday, 0 = unknown.
    function automatic logic [13:0] week_day_chars(input logic [2:0] dow);
        case (dow)
            3'd1:    return {7'h48, 7'h23};
            3'd2:    return {7'h07, 7'h63};
            3'd3:    return {7'h41, 7'h06};
            3'd4:    return {7'h07, 7'h0B};
            3'd5:    return {7'h0E, 7'h2F};
            3'd6:    return {7'h12, 7'h20};
            3'd7:    return {7'h12, 7'h63};
            default: return {SEG_DASH, SEG_DASH};
        endcase
    endfunction

endpackage

// File: rtl/display_pager_debounce.sv
// switch_debouncer: 2-flop synchroniser and a per-bit stability counter.
// A bit's output flips only after DEBOUNCE_CYC consecutive differing samples.
module switch_debouncer #(
    parameter int WIDTH        = 4,
    parameter int DEBOUNCE_CYC = 500_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [WIDTH-1:0] sync1, sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CW-1:0] cnt;
        logic          stb;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt <= '0;
                stb <= 1'b0;
            end else if (sync2[i] == stb) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                stb <= sync2[i];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign stable[i] = stb;
    end

endmodule

// File: rtl/display_pager.sv
// Registered 7-segment pager: debounced page select, timed auto-rotation and
// a 1 Hz blink while DCF77 time is not valid.
module display_pager
    import display_pager_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_FREQ     = 50_000_000,
    parameter int PAGE_SEC     = 3,
    parameter int DEBOUNCE_CYC = 500_000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [3:0]                  sw,
    input  logic                        time_valid,
    input  if_date_time                 clock,
    output logic [NUM_DIGITS-1:0][6:0]  hex,
    output page_t                       page
);
    localparam int PW = $clog2(CLK_FREQ + 1);
    localparam int DW = $clog2(PAGE_SEC + 1);

    logic [3:0]    sw_db;
    logic [PW-1:0] pcnt;
    logic          tick_1hz, blank_phase;
    logic [DW-1:0] dwell, dwell_nxt;
    logic          auto_q;
    page_t         page_nxt, manual_sel;
    logic [7:0][6:0] frame;

    switch_debouncer #(.WIDTH(4), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
        .clk    (clk),
        .reset  (reset),
        .raw    (sw),
        .stable (sw_db)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pcnt <= '0;
        else if (tick_1hz)
            pcnt <= '0;
        else
            pcnt <= pcnt + 1'b1;
    end

    assign tick_1hz    = (pcnt == PW'(CLK_FREQ - 1));
    assign blank_phase = (pcnt >= PW'(CLK_FREQ / 2));

    always_comb begin
        if (sw_db[0])      manual_sel = PG_SEC;
        else if (sw_db[1]) manual_sel = PG_DAY;
        else if (sw_db[2]) manual_sel = PG_DATE;
        else               manual_sel = PG_TIME;
    end

    // The first auto cycle only arms the dwell counter; rotation starts after it.
    always_comb begin
        page_nxt  = page;
        dwell_nxt = dwell;
        if (!sw_db[3]) begin
            page_nxt  = manual_sel;
            dwell_nxt = '0;
        end else if (!auto_q) begin
            dwell_nxt = '0;
        end else if (tick_1hz) begin
            if (dwell == DW'(PAGE_SEC - 1)) begin
                dwell_nxt = '0;
                case (page)
                    PG_TIME: page_nxt = PG_SEC;
                    PG_SEC:  page_nxt = PG_DAY;
                    PG_DAY:  page_nxt = PG_DATE;
                    default: page_nxt = PG_TIME;
                endcase
            end else begin
                dwell_nxt = dwell + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            page   <= PG_TIME;
            dwell  <= '0;
            auto_q <= 1'b0;
        end else begin
            page   <= page_nxt;
            dwell  <= dwell_nxt;
            auto_q <= sw_db[3];
        end
    end

    // frame[0] is the rightmost character of the 8-char page.
    always_comb begin
        frame = {8{SEG_BLANK}};
        case (page)
            PG_TIME: begin
                frame[5] = bcd_digit(clock.hour[7:4]);
                frame[4] = bcd_digit(clock.hour[3:0]);
                frame[3] = bcd_digit(clock.minute[7:4]);
                frame[2] = bcd_digit(clock.minute[3:0]);
                frame[1] = bcd_digit(clock.second[7:4]);
                frame[0] = bcd_digit(clock.second[3:0]);
            end
            PG_SEC: begin
                frame[1] = bcd_digit(clock.second[7:4]);
                frame[0] = bcd_digit(clock.second[3:0]);
            end
            PG_DAY: begin
                {frame[3], frame[2]} = week_day_chars(clock.day_of_week);
                frame[1] = bcd_digit(clock.day[7:4]);
                frame[0] = bcd_digit(clock.day[3:0]);
            end
            default: begin
                frame[5] = bcd_digit(clock.year[7:4]);
                frame[4] = bcd_digit(clock.year[3:0]);
                frame[3] = bcd_digit(clock.month[7:4]);
                frame[2] = bcd_digit(clock.month[3:0]);
                frame[1] = bcd_digit(clock.day[7:4]);
                frame[0] = bcd_digit(clock.day[3:0]);
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hex <= {NUM_DIGITS{SEG_BLANK}};
        else if (!time_valid && blank_phase)
            hex <= {NUM_DIGITS{SEG_BLANK}};
        else
            hex <= frame[NUM_DIGITS-1:0];
    end

endmodule

// File: tb/tb_display_pager.sv
// Directed bench for display_pager: stimulus queues hand-computed expectations
// tagged with a cycle number; a negedge monitor pops and compares them.
module tb_display_pager;
    import display_pager_pkg::*;

    localparam logic [6:0] G0 = 7'h40, G2 = 7'h24, G3 = 7'h30, G4 = 7'h19,
                           G5 = 7'h12, G6 = 7'h02, G7 = 7'h78, G1 = 7'h79,
                           GC = 7'h46, GB = 7'h7F, GT = 7'h07, GU = 7'h63,
                           GD = 7'h3F;

    logic            clk, rst, time_valid;
    logic [3:0]      sw;
    if_date_time     dt;
    logic [3:0][6:0] hex4;
    logic [7:0][6:0] hex8;
    page_t           page4, page8;

    display_pager #(.NUM_DIGITS(4), .CLK_FREQ(10), .PAGE_SEC(2), .DEBOUNCE_CYC(4)) d4 (
        .clk(clk), .reset(rst), .sw(sw), .time_valid(time_valid), .clock(dt),
        .hex(hex4), .page(page4));

    display_pager #(.NUM_DIGITS(8), .CLK_FREQ(10), .PAGE_SEC(2), .DEBOUNCE_CYC(4)) d8 (
        .clk(clk), .reset(rst), .sw(sw), .time_valid(time_valid), .clock(dt),
        .hex(hex8), .page(page8));

    typedef struct {
        int          at;
        bit          wide;
        logic [55:0] hex;
        bit          chk_hex;
        page_t       pg;
        bit          chk_pg;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   rel = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [55:0] h4(input logic [6:0] a, b, c, d);
        return {28'h0, a, b, c, d};
    endfunction

    function automatic logic [55:0] h8(input logic [6:0] a, b, c, d, e, f, g, h);
        return {a, b, c, d, e, f, g, h};
    endfunction

    task automatic push(input int n, input bit wide, input logic [55:0] h, input bit ch,
                        input page_t pg, input bit cp, input string nm);
        exp_t e;
        e.at = rel + n; e.wide = wide; e.hex = h; e.chk_hex = ch;
        e.pg = pg; e.chk_pg = cp; e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic ex4(input int n, input logic [55:0] h, input page_t pg, input string nm);
        push(n, 1'b0, h, 1'b1, pg, 1'b1, nm);
    endtask

    task automatic ex8(input int n, input logic [55:0] h, input string nm);
        push(n, 1'b1, h, 1'b1, PG_TIME, 1'b0, nm);
    endtask

    task automatic exh(input int n, input logic [55:0] h, input string nm);
        push(n, 1'b0, h, 1'b1, PG_TIME, 1'b0, nm);
    endtask

    task automatic exp_pg(input int n, input page_t pg, input string nm);
        push(n, 1'b0, '0, 1'b0, pg, 1'b1, nm);
    endtask

    task automatic wait_to(input int n);
        while (cyc < rel + n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input exp_t e);
        logic [55:0] act;
        page_t       ap;
        act = e.wide ? hex8 : {28'h0, hex4};
        ap  = e.wide ? page8 : page4;
        if (e.chk_hex) begin
            n_tests++;
            if (act !== e.hex) begin
                n_fail++;
                $display("FAIL %s hex @cyc %0d: got %h want %h", e.name, cyc, act, e.hex);
            end
        end
        if (e.chk_pg) begin
            n_tests++;
            if (ap !== e.pg) begin
                n_fail++;
                $display("FAIL %s page @cyc %0d: got %0d want %0d", e.name, cyc, ap, e.pg);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].at == cyc) begin
                check(sbq[i]);
                sbq.delete(i);
            end
        end
    end

    initial begin
        rst = 1'b1; sw = 4'b0000; time_valid = 1'b1;
        dt = '{year: 8'h24, month: 8'h03, day_of_week: 3'd2, day: 8'h07,
               hour: 8'h12, minute: 8'h34, second: 8'h56};

        // reset state, then first frame one cycle after release
        ex4(2, h4(GB, GB, GB, GB), PG_TIME, "reset_blank");
        ex8(3, h8(GB, GB, GB, GB, GB, GB, GB, GB), "reset_blank8");
        wait_to(4);
        rst = 1'b0;
        rel = cyc;
        exh(0, h4(GB, GB, GB, GB), "release_still_blank");
        ex4(1, h4(G3, G4, G5, G6), PG_TIME, "first_time");
        ex8(1, h8(GB, GB, G1, G2, G3, G4, G5, G6), "first_time8");

        // 3-cycle glitch on sw[1] is rejected, held level accepted after 2+4+1
        exp_pg(11, PG_TIME, "glitch_ignored");
        exp_pg(14, PG_TIME, "day_not_yet");
        ex4(15, h4(G3, G4, G5, G6), PG_DAY, "day_page_hex_lag");
        ex4(16, h4(GT, GU, G0, G7), PG_DAY, "day_hex");
        ex8(16, h8(GB, GB, GB, GB, GT, GU, G0, G7), "day_hex8");
        wait_to(2);  sw = 4'b0010;
        wait_to(5);  sw = 4'b0000;
        wait_to(8);  sw = 4'b0010;
        wait_to(20); sw = 4'b0000;
        exp_pg(27, PG_TIME, "back_to_time");
        exh(28, h4(G3, G4, G5, G6), "back_to_time_hex");

        // auto rotation: entry at n=37, ticks at multiples of 10, advance every 20
        exp_pg(49, PG_TIME, "auto_hold_time");
        exp_pg(50, PG_SEC,  "auto_sec");
        exh(51, h4(GB, GB, G5, G6), "auto_sec_hex");
        exp_pg(69, PG_SEC,  "auto_hold_sec");
        exp_pg(70, PG_DAY,  "auto_day");
        exp_pg(89, PG_DAY,  "auto_hold_day");
        exp_pg(90, PG_DATE, "auto_date");
        exh(91, h4(G0, G3, G0, G7), "auto_date_hex");
        ex8(91, h8(GB, GB, G2, G4, G0, G3, G0, G7), "auto_date_hex8");
        exp_pg(109, PG_DATE, "auto_hold_date");
        exp_pg(110, PG_TIME, "auto_wrap_time");
        wait_to(30); sw = 4'b1000;

        exp_pg(118, PG_TIME, "leave_auto_wait");
        exp_pg(119, PG_DATE, "leave_auto_date");
        wait_to(112); sw = 4'b0100;

        // blink with time_valid = 0; page keeps updating underneath
        exh(135, h4(G0, G3, G0, G7), "blink_digits_phase0");
        exh(136, h4(GB, GB, GB, GB), "blink_blank_phase1");
        exp_pg(137, PG_DATE, "blink_page_wait");
        ex4(138, h4(GB, GB, GB, GB), PG_SEC, "blink_page_updates");
        exh(140, h4(GB, GB, GB, GB), "blink_blank_end");
        exh(141, h4(GB, GB, G5, G6), "blink_digits_again");
        exh(146, h4(GB, GB, GB, GB), "blink_blank2");
        exh(147, h4(GB, GB, GB, GB), "tv_rise_pending");
        exh(148, h4(GB, GB, G5, G6), "tv_rise_digits");
        wait_to(130); time_valid = 1'b0;
        wait_to(131); sw = 4'b0001;
        wait_to(147); time_valid = 1'b1;

        // reset in the middle of a dwell period
        exp_pg(164, PG_SEC, "pre_reset_sec");
        ex4(165, h4(GB, GB, GB, GB), PG_TIME, "async_reset");
        ex8(165, h8(GB, GB, GB, GB, GB, GB, GB, GB), "async_reset8");
        wait_to(150); sw = 4'b1000;
        wait_to(165); rst = 1'b1;
        wait_to(167); rst = 1'b0;
        rel = cyc;
        ex4(1, h4(G3, G4, G5, G6), PG_TIME, "post_reset_time");
        exp_pg(19, PG_TIME, "post_reset_dwell");
        exp_pg(20, PG_SEC,  "post_reset_advance");
        exh(21, h4(GB, GB, G5, G6), "post_reset_sec_hex");

        // unknown weekday and illegal BCD month nibble
        exp_pg(29, PG_DAY, "dash_page");
        exh(30, h4(GD, GD, G0, G7), "weekday_dash");
        exp_pg(39, PG_DATE, "illegal_bcd_page");
        exh(40, h4(G0, GC, G0, G7), "illegal_bcd_glyph");
        ex8(40, h8(GB, GB, G2, G4, G0, GC, G0, G7), "illegal_bcd_glyph8");
        wait_to(22);
        dt.day_of_week = 3'd0;
        dt.month = 8'h0C;
        sw = 4'b0010;
        wait_to(32); sw = 4'b0100;
        wait_to(45);

        foreach (sbq[i]) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s expired: check at cyc %0d never reached", sbq[i].name, sbq[i].at);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
